// File: rtl/fpu_status_collector.sv
// Collects FPU completions into a show-ahead FIFO and keeps sticky exception flags, irq and overrun.
// Optional per-flag event counters are enabled by defining FPU_STATUS_CNT_EN.
module fpu_status_collector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
`ifdef FPU_STATUS_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fpu_ready,
    input  logic [DATA_W-1:0]        fpu_result,
    input  logic                     ine,
    input  logic                     overflow,
    input  logic                     underflow,
    input  logic                     div_zero,
    input  logic                     inf,
    input  logic                     zero,
    input  logic                     qnan,
    input  logic                     snan,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [7:0]               out_flags,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               sticky_flags,
    input  logic [7:0]               sticky_clr,
    input  logic [7:0]               irq_mask,
    output logic                     irq,
    output logic                     overrun,
    input  logic                     overrun_clr
`ifdef FPU_STATUS_CNT_EN
    , output logic [8*CNT_W-1:0]     flag_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W+7:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        sticky_q, sticky_d;
    logic              irq_q, irq_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        in_flags;
    logic              full, push, pop;
    logic [DATA_W+7:0] head;

    assign in_flags = {snan, qnan, zero, inf, div_zero, underflow, overflow, ine};

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        pop       = (count_q != '0) && out_ready;
        push      = fpu_ready && (!full || pop);
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Flags of dropped captures still accumulate; set wins over clear.
        sticky_d  = (sticky_q & ~sticky_clr) | (fpu_ready ? in_flags : 8'h00);
        irq_d     = |(sticky_d & irq_mask);
        overrun_d = (overrun_q && !overrun_clr) || (fpu_ready && !push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= '0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage carries no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {in_flags, fpu_result};
        end
    end

    always_comb begin
        head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        out_valid  = (count_q != '0);
        out_result = head[DATA_W-1:0];
        out_flags  = head[DATA_W+7:DATA_W];
    end

    assign fifo_count   = count_q;
    assign sticky_flags = sticky_q;
    assign irq          = irq_q;
    assign overrun      = overrun_q;

`ifdef FPU_STATUS_CNT_EN
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            // Clear first, then increment, so a same-cycle event leaves the counter at 1.
            cnt_d[i] = sticky_clr[i] ? '0 : cnt_q[i];
            if (fpu_ready && in_flags[i] && (cnt_d[i] != '1)) begin
                cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 8; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        flag_cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            flag_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
